serial_add_ctrl: RTL

Bit-serial adder controller. It accepts two WIDTH-bit operands on a start strobe and computes their sum one bit per cycle, LSB first. Each bit step uses the team's two half-add stages: half-add the operand bits, then half-add with the carry. It is the sequencer that lets a single 1-bit add datapath replace a WIDTH-bit ripple adder in area-constrained arithmetic paths.

---
 rtl/serial_add_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//
// Bit-serial adder controller. One 1-bit add datapath (two cascaded half-add
// stages plus a carry flop) is stepped WIDTH times, LSB first, to form the
// full WIDTH-bit sum and carry-out of two operands captured on a start strobe.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request to begin an addition; only sampled in IDLE
//   a, b   WIDTH-bit operands, captured on the accepting edge
//   busy   high while bits are being processed (ADD state)
//   done   one-cycle pulse when s/c have just been updated (DONE state)
//   s      registered sum, holds until the next completion
//   c      registered carry-out of the MSB, holds with s

module serial_add_ctrl #(
    parameter int WIDTH = 8   // legal range 2..32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             cy;
    logic [CW-1:0]    cnt;

    // Bit-step datapath: two half-add stages sharing the carry flop.
    logic p;        // stage 1 sum (propagate)
    logic g;        // stage 1 carry (generate)
    logic sum_bit;  // stage 2 sum
    logic cy_next;

    // NOTE: every output of a combinational block is assigned on every path
    // (here unconditionally) so no latch can be inferred.
    always_comb begin
        p       = a_sh[0] ^ b_sh[0];
        g       = a_sh[0] & b_sh[0];
        sum_bit = p ^ cy;
        cy_next = g | (p & cy);
    end

    // Registered-state decodes: no combinational path from start.
    assign busy = (state == ADD);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of statement order.
    // NOTE: the shift registers are plain flops, not a memory array, so they
    // are cleared by reset along with the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            c     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        cy    <= 1'b0;
                        cnt   <= '0;
                        state <= ADD;
                    end
                end

                ADD: begin
                    s_sh <= {sum_bit, s_sh[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cy   <= cy_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // Publish the final bit straight from the datapath so
                        // s/c are valid in the DONE cycle itself.
                        s     <= {sum_bit, s_sh[WIDTH-1:1]};
                        c     <= cy_next;
                        state <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
